byte_serial_adder: RTL and testbench
====================================

# byte_serial_adder

Multi-cycle wide adder that accepts two `8*NUM_BYTES`-bit operands over a valid/ready handshake and adds them one byte per clock. It uses a single 8-bit carry-lookahead slice and carries between bytes in a register. It sits directly upstream of the 8-bit lookahead adder datapath, sequencing operands into it and collecting its sum and carry. It trades latency for area on wide additions.

## Interface
- `NUM_BYTES`, default 4: operand width in bytes; legal range 2..16.
- `W` is a derived localparam equal to `8*NUM_BYTES`; it is not overridable.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands.
- `in_a` input W: operand A, unsigned or two's complement.
- `in_b` input W: operand B.
- `in_cin` input 1: carry into byte 0.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `out_sum` output W: A+B+cin, modulo 2^W.
- `out_cout` output 1: carry out of the most significant byte.
- `out_ovf` output 1: signed overflow flag; see Configuration.
- `busy` output 1: high in RUN or DONE.

## Operation
The FSM has three states: IDLE, RUN and DONE. It is encoded as 2 bits.

**IDLE**
- `in_ready`=1.
- When `in_valid`&&`in_ready`: capture `in_a` and `in_b` into shift registers A_q and B_q, capture `in_cin` into carry_q, clear byte index idx_q to 0, then go to RUN.

**RUN**
- `in_ready`=0.
- Each cycle, the slice adds A_q[7:0] + B_q[7:0] + carry_q.
- carry_q <= slice carry-out.
- A_q and B_q shift right by 8.
- The slice sum is inserted at S_q[W-1:W-8] while S_q shifts right by 8. After NUM_BYTES cycles, byte 0 therefore sits in S_q[7:0].
- idx_q increments. When idx_q==NUM_BYTES-1, go to DONE.

**DONE**
- `out_valid`=1.
- `out_sum`=S_q, `out_cout`=carry_q and `out_ovf` are held stable.
- On `out_valid`&&`out_ready`, go to IDLE.

**Boundary behaviour**
- `in_valid` asserted during RUN or DONE is ignored. The operand is not captured and the upstream must hold it.
- `out_ready` held high in advance does not shorten RUN. The result still appears exactly on schedule and is consumed in its first DONE cycle.
- `out_ready` low: DONE holds indefinitely with all outputs frozen.
- Carry-out wraps: the sum is modulo 2^W and the carry is reported only via `out_cout`.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded with no partial `out_valid`.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0, `busy`=0. All datapath registers are cleared.
- **Latency:** operands accepted at edge T; RUN occupies cycles T+1..T+NUM_BYTES; `out_valid` rises after edge T+NUM_BYTES and is visible for the first time in cycle T+NUM_BYTES+1.
- **Throughput:** one operation per NUM_BYTES+2 cycles maximum, with no overlap.
- **Combinational paths:** `in_ready`, `out_valid` and `busy` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready` to any output.
- The slice sits between registers, so the critical path is one 8-bit lookahead plus the shift mux.

## Configuration
- `BYTE_SERIAL_ADDER_OVF_EN` defined:
  - During the final RUN cycle, register ovf_q = (a7==b7)&&(s7!=a7), taken on the top byte's MSBs.
  - `out_ovf` = ovf_q in DONE, and 0 otherwise.
- Not defined:
  - `out_ovf` is tied to 0.
  - No ovf_q register exists.
  - The port remains present.

## Structure
- **Package `byte_serial_adder_pkg`:**
  - `BYTE_W`=8.
  - typedef enum `bsa_state_t` {IDLE, RUN, DONE}.
  - Function `bsa_latency(n)` returning n+1.
- **Sub-module `cla8_slice`:** combinational 8-bit carry-lookahead (p/g with flattened carry equations). It has inputs a[7:0], b[7:0], ci and outputs s[7:0], co. It is instantiated once.
- The top level holds the FSM, shift registers, carry register and index counter.

## Test plan
All cases use NUM_BYTES=4.
1. 0xFFFFFFFF+0x00000001, cin=0 -> `out_sum`=0x00000000, `out_cout`=1, `out_ovf`=0; `out_valid` first seen 5 cycles after acceptance.
2. 0x7FFFFFFF+0x00000001, cin=0 with macro defined -> `out_sum`=0x80000000, `out_cout`=0, `out_ovf`=1. Without the macro, `out_ovf`=0.
3. 0x12345678+0x11111111, cin=1 -> `out_sum`=0x2345678A. Hold `out_ready`=0 for 6 cycles: sum stays stable, `in_ready`=0 and a second `in_valid` is ignored.
4. Back-to-back requests with `out_ready`=1 throughout -> accepts spaced 6 cycles apart, each result correct.
5. Assert `rst_n`=0 during the 2nd RUN cycle -> all outputs return to reset values immediately. After release, `in_ready`=1 and a new add completes correctly.
6. 0x80000000+0x80000000 -> `out_sum`=0, `out_cout`=1, `out_ovf`=1 (macro defined).

Source files
------------

// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial wide adder.
// Signed overflow reporting is enabled with BYTE_SERIAL_ADDER_OVF_EN.
package byte_serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

  function automatic int bsa_latency(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/byte_serial_adder_cla8.sv
// 8-bit carry-lookahead slice; every carry is a flat
// sum of generate/propagate products rather than a ripple chain.
module cla8_slice
  import byte_serial_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic [BYTE_W-1:0] p;
  logic [BYTE_W-1:0] g;
  logic [BYTE_W:0]   c;
  logic              prod;
  logic              term;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
  always_comb begin
    c    = '0;
    prod = 1'b0;
    term = 1'b0;
    c[0] = ci;
    for (int i = 0; i < BYTE_W; i++) begin
      prod = p[i];
      term = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = term | (prod & ci);
    end
  end

  assign s  = p ^ c[BYTE_W-1:0];
  assign co = c[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder processing one byte per clock through a single CLA slice.
// Define BYTE_SERIAL_ADDER_OVF_EN to drive out_ovf with signed overflow.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter  int NUM_BYTES = 4,
  localparam int W         = BYTE_W * NUM_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  bsa_state_t state_q, state_d;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [BYTE_W-1:0] sl_s;
  logic              sl_co;
  logic              last;

  cla8_slice u_slice (
    .a  (a_q[BYTE_W-1:0]),
    .b  (b_q[BYTE_W-1:0]),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  assign last = (idx_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bytes enter at the top so byte 0 lands at the bottom.
        a_d     = {{BYTE_W{1'b0}}, a_q[W-1:BYTE_W]};
        b_d     = {{BYTE_W{1'b0}}, b_q[W-1:BYTE_W]};
        s_d     = {sl_s, s_q[W-1:BYTE_W]};
        carry_d = sl_co;
        idx_d   = idx_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = s_q;
  assign out_cout  = carry_q;

`ifdef BYTE_SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  // Top byte MSBs are only in the slice during the final RUN cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && last) begin
      ovf_d = (a_q[BYTE_W-1] == b_q[BYTE_W-1]) &&
              (sl_s[BYTE_W-1] != a_q[BYTE_W-1]);
    end
  end

  assign out_ovf = (state_q == DONE) && ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_byte_serial_adder.sv
// Randomized self-checking bench for byte_serial_adder against
// a plain-arithmetic reference model.
module tb_byte_serial_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

`ifdef BYTE_SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  byte_serial_adder #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum} for a + b + cin.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic cin);
    logic [W:0] t;
    logic       v;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {OVF_ON & v, t};
  endfunction

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic cin,
                        input int hold,
                        input bit early,
                        input bit poke);
    logic [W+1:0] e;
    int n;
    e = model(a, b, cin);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rdy_wait", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin;
    in_valid = 1'b1;
    out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    check("run_busy", busy, 1);
    check("run_rdy", in_ready, 0);
    n = 1;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, NB + 1);
    check("sum", out_sum, e[W-1:0]);
    check("cout", out_cout, e[W]);
    check("ovf", out_ovf, e[W+1]);
    check("done_busy", busy, 1);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_a = $urandom; in_b = $urandom;
      end
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, e[W-1:0]);
      check("hold_cout", out_cout, e[W]);
      check("hold_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("consumed", out_valid, 0);
    check("idle_rdy", in_ready, 1);
    check("idle_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  task automatic back_to_back(input int nops);
    logic [W+1:0] exp_q[$];
    int acc_q[$];
    logic [W-1:0] oa[$];
    logic [W-1:0] ob[$];
    logic oc[$];
    int k, got;
    bit pend;
    for (int i = 0; i < nops; i++) begin
      oa.push_back($urandom);
      ob.push_back($urandom);
      oc.push_back(1'($urandom));
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_a = oa[0]; in_b = ob[0]; in_cin = oc[0];
    in_valid = 1'b1;
    k = 1; got = 0; pend = 1'b0;
    for (int t = 0; t < 200 && got < nops; t++) begin
      if (pend) begin
        if (k < nops) begin
          in_a = oa[k]; in_b = ob[k]; in_cin = oc[k];
          k++;
        end else begin
          in_valid = 1'b0;
        end
        pend = 1'b0;
      end
      if (out_valid) begin
        check("b2b_queue", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("b2b_sum", out_sum, exp_q[0][W-1:0]);
          check("b2b_cout", out_cout, exp_q[0][W]);
          check("b2b_ovf", out_ovf, exp_q[0][W+1]);
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        pend = 1'b1;
        exp_q.push_back(model(in_a, in_b, in_cin));
        acc_q.push_back(cyc);
      end
      @(negedge clk);
    end
    check("b2b_count", got, nops);
    for (int i = 1; i < acc_q.size(); i++)
      check("b2b_gap", acc_q[i] - acc_q[i-1], NB + 2);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic reset_mid_run();
    bit seen;
    @(negedge clk);
    in_a = 32'hDEADBEEF; in_b = 32'h01234567; in_cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_rdy", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_ovf", out_ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("rst_no_valid", seen, 0);
    check("rst_rel_rdy", in_ready, 1);
    run_op(32'hCAFEF00D, 32'h0F0F0F0F, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_rdy", in_ready, 1);
    check("reset_valid", out_valid, 0);
    check("reset_sum", out_sum, 0);
    check("reset_cout", out_cout, 0);
    check("reset_ovf", out_ovf, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b1, 1'b0);
    run_op(32'h12345678, 32'h11111111, 1'b1, 6, 1'b0, 1'b1);
    back_to_back(4);
    reset_mid_run();
    run_op(32'h80000000, 32'h80000000, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      int h;
      bit early;
      h = $urandom_range(0, 2);
      early = (h == 0) && ($urandom_range(0, 1) == 1);
      run_op($urandom, $urandom, 1'($urandom), h, early, h > 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
